fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 128 ++++++++++++
 tb/tb_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry in-order instruction queue, pipelined memory requests
// and redirect flush. Optional misaligned-fetch fault entry under FETCH_MISALIGN_CHECK_EN.
module fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_vec,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_next_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_pc, r_resp_pc;
  logic [CW-1:0]   r_count, r_inflight, r_discard;
  logic [AW-1:0]   r_head, r_tail;
  logic [XLEN-1:0] r_q_pc    [DEPTH];
  logic [XLEN-1:0] r_q_instr [DEPTH];

  logic            w_redirect, w_room, w_fetch_ok, w_fault_enq;
  logic            w_req_fire, w_resp_keep, w_enq, w_deq;
  logic [XLEN-1:0] w_target, w_enq_pc, w_enq_instr;
  logic [CW:0]     w_occ;

  assign w_redirect = trap | branch;
  assign w_target   = trap ? trap_vec : branch_vec;
  assign w_occ      = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_room     = w_occ < (CW+1)'(DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_halt;
  logic r_q_mis [DEPTH];
  logic w_misaligned;

  assign w_misaligned = r_pc[1:0] != 2'b00;
  assign w_fetch_ok   = !w_misaligned && !r_halt;
  // The fault entry waits for outstanding responses so it stays in program order.
  assign w_fault_enq  = w_misaligned && !r_halt && !w_redirect &&
                        (r_inflight == '0) && (r_count < CW'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_halt <= 1'b0;
    else if (w_redirect) r_halt <= 1'b0;
    else if (w_fault_enq) r_halt <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_enq) r_q_mis[r_tail] <= w_fault_enq;
  end

  assign out_misaligned = r_q_mis[r_head];
`else
  assign w_fetch_ok     = 1'b1;
  assign w_fault_enq    = 1'b0;
  assign out_misaligned = 1'b0;
`endif

  assign req_valid   = !reset && !w_redirect && w_room && w_fetch_ok;
  assign req_addr    = r_pc;
  assign w_req_fire  = req_valid && req_ready;
  assign w_resp_keep = resp_valid && !w_redirect && (r_discard == '0);
  assign w_enq       = w_resp_keep || w_fault_enq;
  assign w_enq_pc    = w_fault_enq ? r_pc : r_resp_pc;
  assign w_enq_instr = w_fault_enq ? '0 : resp_data;

  assign out_valid   = (r_count != '0) && !w_redirect;
  assign w_deq       = out_valid && out_ready;
  assign out_pc      = r_q_pc[r_head];
  assign out_next_pc = r_q_pc[r_head] + XLEN'(4);
  assign out_instr   = r_q_instr[r_head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_VEC;
      r_resp_pc  <= RESET_VEC;
      r_count    <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (w_redirect) begin
      r_pc       <= w_target;
      r_resp_pc  <= w_target;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= r_inflight - CW'(resp_valid);
      // Everything still owed is stale; r_discard is already a subset of r_inflight.
      r_discard  <= r_inflight - CW'(resp_valid);
    end else begin
      if (w_req_fire) r_pc <= r_pc + XLEN'(4);
      if (w_resp_keep) r_resp_pc <= r_resp_pc + XLEN'(4);
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(resp_valid);
      if (resp_valid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      if (w_enq) r_tail <= r_tail + AW'(1);
      if (w_deq) r_head <= r_head + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_pc[r_tail]    <= w_enq_pc;
      r_q_instr[r_tail] <= w_enq_instr;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && resp_valid) assert (r_inflight != '0);
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with an in-order memory model
// (1-cycle latency, optional hold); set FETCH_MISALIGN_CHECK_EN to cover the fault entry.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        reset, trap, branch, req_ready, resp_valid, out_ready;
  logic [31:0] trap_vec, branch_vec, resp_data;
  logic        req_valid, out_valid, out_misaligned;
  logic [31:0] req_addr, out_pc, out_next_pc, out_instr;

  int checks = 0;
  int errors = 0;
  int fire_cnt = 0;
  int cyc = 0;
  logic        mem_hold;
  logic [31:0] pend[$];
  logic [31:0] got_pc[$], got_npc[$], got_instr[$];
  logic        got_mis[$];
  int          got_cyc[$];

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_VEC(32'h0)) dut (
    .clk(clk), .reset(reset), .trap(trap), .trap_vec(trap_vec),
    .branch(branch), .branch_vec(branch_vec),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_next_pc(out_next_pc), .out_instr(out_instr), .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory: requests accepted at an edge are answered in the following cycle unless held.
  always @(posedge clk) begin
    if (reset) begin
      pend.delete();
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      if (req_valid && req_ready) pend.push_back(req_addr);
      if (!mem_hold && pend.size() > 0) begin
        resp_valid <= 1'b1;
        resp_data  <= mem_word(pend.pop_front());
      end else begin
        resp_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      if (req_valid && req_ready) fire_cnt++;
      if (out_valid && out_ready) begin
        got_pc.push_back(out_pc);
        got_npc.push_back(out_next_pc);
        got_instr.push_back(out_instr);
        got_mis.push_back(out_misaligned);
        got_cyc.push_back(cyc);
        $display("deq  cyc=%0d pc=%h next=%h instr=%h mis=%0b", cyc, out_pc, out_next_pc, out_instr, out_misaligned);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trap = 0; branch = 0; trap_vec = '0; branch_vec = '0;
    req_ready = 0; out_ready = 0; mem_hold = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic redirect(input logic t, input logic [31:0] tv, input logic b, input logic [31:0] bv);
    trap = t; trap_vec = tv; branch = b; branch_vec = bv;
    tick();
    trap = 0; branch = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req_ready = 1; out_ready = 1;
    reset = 1;
    tick();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 00000000", req_addr); end
    reset = 0;
    #1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL reset_release_req_valid: got %b expected 1", req_valid); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    int gb;
    apply_reset();
    gb = got_pc.size();
    req_ready = 1; out_ready = 1;
    repeat (12) tick();
    checks++; if (got_pc.size() - gb !== 10) begin errors++; $display("FAIL stream_count: got %0d expected 10", got_pc.size() - gb); end
    for (int i = 0; i < 6; i++) begin
      if (gb + i < got_pc.size()) begin
        checks++; if (got_pc[gb+i] !== 32'(4*i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, got_pc[gb+i], 32'(4*i)); end
        checks++; if (got_npc[gb+i] !== 32'(4*i+4)) begin errors++; $display("FAIL stream_next_pc[%0d]: got %h expected %h", i, got_npc[gb+i], 32'(4*i+4)); end
        checks++; if (got_instr[gb+i] !== mem_word(32'(4*i))) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, got_instr[gb+i], mem_word(32'(4*i))); end
        checks++; if (got_mis[gb+i] !== 1'b0) begin errors++; $display("FAIL stream_mis[%0d]: got %b expected 0", i, got_mis[gb+i]); end
        if (i > 0) begin
          checks++; if (got_cyc[gb+i] - got_cyc[gb+i-1] !== 1) begin errors++; $display("FAIL stream_rate[%0d]: gap %0d expected 1", i, got_cyc[gb+i] - got_cyc[gb+i-1]); end
        end
      end
    end
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    int fb, gb;
    logic [31:0] exp_pc;
    apply_reset();
    fb = fire_cnt;
    req_ready = 1; out_ready = 0;
    repeat (8) tick();
    checks++; if (fire_cnt - fb !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", fire_cnt - fb); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", req_valid); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 00000000", out_pc); end
    gb = got_pc.size();
    out_ready = 1;
    repeat (4) tick();
    checks++; if (got_pc.size() - gb !== 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", got_pc.size() - gb); end
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(4*i);
      if (gb + i < got_pc.size()) begin
        checks++; if (got_pc[gb+i] !== exp_pc) begin errors++; $display("FAIL bp_drain_pc[%0d]: got %h expected %h", i, got_pc[gb+i], exp_pc); end
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_branch_flush();
    int fb, gb, stale;
    apply_reset();
    mem_hold = 1; req_ready = 1; out_ready = 1;
    fb = fire_cnt;
    repeat (3) tick();
    checks++; if (fire_cnt - fb !== 3) begin errors++; $display("FAIL flush_inflight: got %0d expected 3", fire_cnt - fb); end
    branch = 1; branch_vec = 32'h100; mem_hold = 0;
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL flush_req_blocked: got %b expected 0", req_valid); end
    gb = got_pc.size();
    tick();
    branch = 0;
    #1;
    checks++; if (req_addr !== 32'h100) begin errors++; $display("FAIL flush_req_addr: got %h expected 00000100", req_addr); end
    repeat (12) tick();
    checks++; if (got_pc.size() <= gb) begin errors++; $display("FAIL flush_no_output: got %0d entries expected >0", got_pc.size() - gb); end
    else begin
      checks++; if (got_pc[gb] !== 32'h100) begin errors++; $display("FAIL flush_first_pc: got %h expected 00000100", got_pc[gb]); end
      checks++; if (got_instr[gb] !== mem_word(32'h100)) begin errors++; $display("FAIL flush_first_instr: got %h expected %h", got_instr[gb], mem_word(32'h100)); end
    end
    stale = 0;
    for (int i = gb; i < got_pc.size(); i++) if (got_pc[i] < 32'h100) stale++;
    checks++; if (stale !== 0) begin errors++; $display("FAIL flush_stale_entries: got %0d expected 0", stale); end
    $display("test_branch_flush done");
  endtask

  task automatic test_double_redirect();
    int gb;
    repeat (3) tick();
    gb = got_pc.size();
    branch = 1; branch_vec = 32'h300;
    tick();
    redirect(1'b0, 32'h0, 1'b1, 32'h400);
    #1;
    checks++; if (req_addr !== 32'h400) begin errors++; $display("FAIL double_req_addr: got %h expected 00000400", req_addr); end
    repeat (8) tick();
    checks++; if (got_pc.size() <= gb) begin errors++; $display("FAIL double_no_output: got 0 entries expected >0"); end
    else begin
      checks++; if (got_pc[gb] !== 32'h400) begin errors++; $display("FAIL double_first_pc: got %h expected 00000400", got_pc[gb]); end
      checks++; if (got_instr[gb] !== mem_word(32'h400)) begin errors++; $display("FAIL double_first_instr: got %h expected %h", got_instr[gb], mem_word(32'h400)); end
    end
    $display("test_double_redirect done");
  endtask

  task automatic test_trap_priority();
    int gb;
    gb = got_pc.size();
    redirect(1'b1, 32'h80, 1'b1, 32'h200);
    #1;
    checks++; if (req_addr !== 32'h80) begin errors++; $display("FAIL trap_req_addr: got %h expected 00000080", req_addr); end
    repeat (8) tick();
    checks++; if (got_pc.size() <= gb) begin errors++; $display("FAIL trap_no_output: got 0 entries expected >0"); end
    else begin
      checks++; if (got_pc[gb] !== 32'h80) begin errors++; $display("FAIL trap_first_pc: got %h expected 00000080", got_pc[gb]); end
    end
    $display("test_trap_priority done");
  endtask

  task automatic test_wrap();
    int gb;
    gb = got_pc.size();
    redirect(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    #1;
    checks++; if (req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_addr0: got %h expected fffffffc", req_addr); end
    tick();
    checks++; if (req_addr !== 32'h0) begin errors++; $display("FAIL wrap_req_addr1: got %h expected 00000000", req_addr); end
    repeat (6) tick();
    checks++; if (got_pc.size() < gb + 2) begin errors++; $display("FAIL wrap_count: got %0d expected >=2", got_pc.size() - gb); end
    else begin
      checks++; if (got_pc[gb] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h expected fffffffc", got_pc[gb]); end
      checks++; if (got_npc[gb] !== 32'h0) begin errors++; $display("FAIL wrap_next_pc0: got %h expected 00000000", got_npc[gb]); end
      checks++; if (got_pc[gb+1] !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h expected 00000000", got_pc[gb+1]); end
    end
    $display("test_wrap done");
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    int fb, gb;
    gb = got_pc.size();
    redirect(1'b0, 32'h0, 1'b1, 32'h102);
    fb = fire_cnt;
    repeat (10) tick();
    checks++; if (fire_cnt - fb !== 0) begin errors++; $display("FAIL mis_requests: got %0d expected 0", fire_cnt - fb); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL mis_req_valid: got %b expected 0", req_valid); end
    checks++; if (got_pc.size() - gb !== 1) begin errors++; $display("FAIL mis_entries: got %0d expected 1", got_pc.size() - gb); end
    if (got_pc.size() > gb) begin
      checks++; if (got_pc[gb] !== 32'h102) begin errors++; $display("FAIL mis_pc: got %h expected 00000102", got_pc[gb]); end
      checks++; if (got_mis[gb] !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b expected 1", got_mis[gb]); end
      checks++; if (got_instr[gb] !== 32'h0) begin errors++; $display("FAIL mis_instr: got %h expected 00000000", got_instr[gb]); end
    end
    gb = got_pc.size();
    redirect(1'b1, 32'h40, 1'b0, 32'h0);
    #1;
    checks++; if (req_addr !== 32'h40 || req_valid !== 1'b1) begin errors++; $display("FAIL mis_resume: got addr %h valid %b expected 00000040 1", req_addr, req_valid); end
    repeat (6) tick();
    checks++; if (got_pc.size() <= gb) begin errors++; $display("FAIL mis_resume_output: got 0 entries expected >0"); end
    else begin
      checks++; if (got_pc[gb] !== 32'h40 || got_mis[gb] !== 1'b0) begin errors++; $display("FAIL mis_resume_entry: got pc %h mis %b expected 00000040 0", got_pc[gb], got_mis[gb]); end
    end
    $display("test_misalign done");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_stream();
    test_reset();
    test_backpressure();
    test_branch_flush();
    test_double_redirect();
    test_trap_priority();
    test_wrap();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
